ahb_prio_arbiter: RTL and testbench

- Parametrised AHB bus arbiter for NUM_MAS masters with per-master programmable priority of PRIO_BITS bits.
- Sits between the master-side AHB interfaces and the shared address/control mux; drives hgrant, hmaster and hmastlock.
- Honours fixed-length bursts and locked transfers.
- Breaks priority ties round-robin, and parks the bus on master 0 when no master is requesting.

---
 rtl/ahb_prio_arbiter_if.sv | 28 ++
 rtl/ahb_prio_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_prio_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_prio_arbiter_if.sv
// AHB arbiter bus bundle: master-side requests in, grant and owner out.
// The slave modport is the arbiter's view; the master modport drives it.
interface ahb_prio_arbiter_if #(
    parameter int NUM_MAS   = 4,
    parameter int PRIO_BITS = 3
);
    localparam int MW = $clog2(NUM_MAS);

    logic [NUM_MAS-1:0]           hbusreq;
    logic [NUM_MAS-1:0]           hlock;
    logic [NUM_MAS*PRIO_BITS-1:0] prio;
    logic [1:0]                   htrans;
    logic [2:0]                   hburst;
    logic                         hready;
    logic [NUM_MAS-1:0]           hgrant;
    logic [MW-1:0]                hmaster;
    logic                         hmastlock;

    modport slave (
        input  hbusreq, hlock, prio, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, prio, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_prio_arbiter.sv
// AHB priority arbiter with round-robin tie-break, burst/lock hold, park on m0.
// Optional starvation aging is enabled by defining ARB_AGING_EN.
module ahb_prio_arbiter #(
    parameter int NUM_MAS   = 4,
    parameter int PRIO_BITS = 3,
    parameter int AGE_LIMIT = 15
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_prio_arbiter_if.slave   bus
);
    localparam int MW = $clog2(NUM_MAS);
    localparam int EW = PRIO_BITS + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    typedef enum logic [1:0] {PARK, OWN, BURST, LOCK} state_t;

    if (NUM_MAS < 2 || NUM_MAS > 16 || PRIO_BITS < 1 || AGE_LIMIT < 1) begin : g_bad_cfg
        $error("ahb_prio_arbiter: unsupported parameter set");
    end

    state_t             state_q, state_nx, ts_state;
    logic [3:0]         cnt_q, cnt_nx, ts_cnt, blen;
    logic [MW-1:0]      gnt_q, gnt_nx;
    logic [MW-1:0]      rr_q, rr_nx;
    logic [MW-1:0]      mst_q, mst_nx;
    logic [MW-1:0]      win;
    logic               lck_q, lck_nx;
    logic [NUM_MAS-1:0] hgrant_q;
    logic               rearb, any_req, fixed, mine, own_lock;
    logic [EW-1:0]      ep [NUM_MAS];
    logic [EW-1:0]      best;
    int                 idx;

`ifdef ARB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [AW-1:0] age_q [NUM_MAS];
`endif

    assign mine     = (mst_q == gnt_q);
    assign own_lock = bus.hlock[mst_q];
    assign fixed    = (blen != 4'd0);

    always_comb begin
        unique case (bus.hburst)
            3'd2, 3'd3: blen = 4'd3;
            3'd4, 3'd5: blen = 4'd7;
            3'd6, 3'd7: blen = 4'd15;
            default:    blen = 4'd0;
        endcase
    end

    // Effective priority; a fully aged master sits above every real level.
    always_comb begin
        for (int i = 0; i < NUM_MAS; i++) begin
            ep[i] = {1'b0, bus.prio[i*PRIO_BITS +: PRIO_BITS]};
`ifdef ARB_AGING_EN
            if (age_q[i] == AW'(AGE_LIMIT))
                ep[i] = EW'(1) << PRIO_BITS;
`endif
        end
    end

    // Scan from rr_q+1 upward; strict > keeps the first of any tie.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        best    = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_MAS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_MAS)
                idx = idx - NUM_MAS;
            if (bus.hbusreq[idx] && (!any_req || ep[idx] > best)) begin
                any_req = 1'b1;
                best    = ep[idx];
                win     = MW'(idx);
            end
        end
    end

    always_comb begin
        rearb = 1'b0;
        if (bus.hready) begin
            unique case (state_q)
                PARK, OWN: rearb = 1'b1;
                BURST:     rearb = (cnt_q == 4'd1) || (bus.htrans == IDLE)
                                   || (bus.htrans == NONSEQ);
                LOCK:      rearb = !own_lock;
                default:   rearb = 1'b0;
            endcase
        end
    end

    // Next state: transfer tracking applies only while owner keeps the grant.
    always_comb begin
        ts_state = OWN;
        ts_cnt   = '0;
        if (mine) begin
            unique case (state_q)
                BURST: begin
                    ts_state = BURST;
                    ts_cnt   = cnt_q;
                    if (bus.htrans == SEQ)
                        ts_cnt = cnt_q - 4'd1;
                    if (ts_cnt == 4'd0)
                        ts_state = OWN;
                end
                LOCK: begin
                    if (own_lock)
                        ts_state = LOCK;
                end
                default: ;
            endcase
            if (bus.htrans == NONSEQ) begin
                ts_cnt = blen;
                if (own_lock)
                    ts_state = LOCK;
                else if (fixed)
                    ts_state = BURST;
                else
                    ts_state = OWN;
            end else if (bus.htrans == IDLE && state_q == BURST) begin
                ts_cnt   = '0;
                ts_state = OWN;
            end
        end

        state_nx = state_q;
        cnt_nx   = cnt_q;
        if (bus.hready) begin
            if (rearb && !any_req) begin
                state_nx = PARK;
                cnt_nx   = '0;
            end else if (rearb && win != gnt_q) begin
                state_nx = OWN;
                cnt_nx   = '0;
            end else begin
                state_nx = ts_state;
                cnt_nx   = ts_cnt;
            end
        end
    end

    always_comb begin
        gnt_nx = gnt_q;
        rr_nx  = rr_q;
        mst_nx = mst_q;
        lck_nx = lck_q;
        if (rearb) begin
            if (!any_req) begin
                gnt_nx = '0;
            end else begin
                gnt_nx = win;
                if (win != gnt_q)
                    rr_nx = win;
            end
        end
        if (bus.hready) begin
            mst_nx = gnt_q;
            lck_nx = bus.hlock[gnt_q];
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= PARK;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rr_q     <= '0;
            mst_q    <= '0;
            lck_q    <= 1'b0;
            hgrant_q <= NUM_MAS'(1);
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            gnt_q    <= gnt_nx;
            rr_q     <= rr_nx;
            mst_q    <= mst_nx;
            lck_q    <= lck_nx;
            hgrant_q <= NUM_MAS'(1) << gnt_nx;
        end
    end

`ifdef ARB_AGING_EN
    always_ff @(posedge hclk) begin
        for (int i = 0; i < NUM_MAS; i++) begin
            if (!hresetn || !bus.hbusreq[i])
                age_q[i] <= '0;
            else if (rearb) begin
                if (any_req && win == MW'(i))
                    age_q[i] <= '0;
                else if (age_q[i] != AW'(AGE_LIMIT))
                    age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end
`endif

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = mst_q;
    assign bus.hmastlock = lck_q;
endmodule

// File: tb/tb_ahb_prio_arbiter.sv
// Scoreboard bench for ahb_prio_arbiter: expectations queued per clock,
// checked on the following falling edge.
module tb_ahb_prio_arbiter;
    localparam int NM = 4;
    localparam int PB = 3;
`ifdef ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

    logic hclk = 1'b0;
    logic hresetn;

    ahb_prio_arbiter_if #(.NUM_MAS(NM), .PRIO_BITS(PB)) bus ();

    ahb_prio_arbiter #(
        .NUM_MAS  (NM),
        .PRIO_BITS(PB),
        .AGE_LIMIT(3)
    ) u_dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        string tag;
        int    g;
        int    m;
        int    l;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vecs = 0;
    int   errs = 0;

    task automatic check(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Queue the expected outputs after the next rising edge, then take it.
    task automatic tick(input string tag, input int g, input int m, input int l);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.m   = m;
        e.l   = l;
        sb.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    always @(negedge hclk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            if (cur.g >= 0) check({cur.tag, "/hgrant"}, int'(bus.hgrant), cur.g);
            if (cur.m >= 0) check({cur.tag, "/hmaster"}, int'(bus.hmaster), cur.m);
            if (cur.l >= 0) check({cur.tag, "/hmastlock"}, int'(bus.hmastlock), cur.l);
        end
    end

    task automatic do_reset();
        hresetn     = 1'b0;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = IDLE;
        bus.hburst  = 3'd0;
        bus.hready  = 1'b1;
        tick("reset", 1, 0, 0);
        hresetn = 1'b1;
    endtask

    initial begin
        hresetn     = 1'b0;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.prio    = '0;
        bus.htrans  = IDLE;
        bus.hburst  = 3'd0;
        bus.hready  = 1'b1;

        tick("rst0", 1, 0, 0);
        tick("rst1", 1, 0, 0);
        hresetn = 1'b1;
        tick("park0", 1, 0, 0);
        tick("park1", 1, 0, 0);

        // priority pick, then owner drop and park
        bus.prio    = {3'd3, 3'd5, 3'd1, 3'd2};
        bus.hbusreq = 4'b1111;
        tick("pri_g", 4, 0, 0);
        tick("pri_m", 4, 2, 0);
        bus.hbusreq = 4'b1011;
        tick("drop", 8, 2, 0);
        bus.hbusreq = 4'b0000;
        tick("park_a", 1, 3, 0);
        tick("park_b", 1, 0, 0);

        // INCR4 held against a higher-priority requester
        do_reset();
        bus.prio    = {3'd7, 3'd0, 3'd5, 3'd0};
        bus.hbusreq = 4'b0010;
        tick("b_gnt", 2, 0, 0);
        tick("b_own", 2, 1, 0);
        bus.htrans  = NONSEQ;
        bus.hburst  = 3'd3;
        tick("b_beat1", 2, 1, 0);
        bus.htrans  = SEQ;
        bus.hbusreq = 4'b1010;
        tick("b_beat2", 2, 1, 0);
        bus.hready  = 1'b0;
        tick("b_beat3w", 2, 1, 0);
        bus.hready  = 1'b1;
        tick("b_beat3", 2, 1, 0);
        tick("b_beat4", 8, 1, 0);
        bus.htrans  = IDLE;
        bus.hburst  = 3'd0;
        tick("b_new", 8, 3, 0);

        // equal priorities rotate
        do_reset();
        bus.prio    = {3'd4, 3'd4, 3'd4, 3'd4};
        bus.hbusreq = 4'b1111;
        bus.htrans  = NONSEQ;
        tick("rr1", 2, 0, 0);
        tick("rr2", 4, 1, 0);
        tick("rr3", 8, 2, 0);
        tick("rr4", 1, 3, 0);
        tick("rr5", 2, 0, 0);

        // locked INCR8 by m0 holds off m2
        do_reset();
        bus.prio    = {3'd0, 3'd7, 3'd0, 3'd1};
        bus.hbusreq = 4'b0001;
        bus.hlock   = 4'b0001;
        tick("l_gnt", 1, 0, 1);
        bus.htrans  = NONSEQ;
        bus.hburst  = 3'd5;
        tick("l_start", 1, 0, 1);
        bus.htrans  = SEQ;
        bus.hbusreq = 4'b0101;
        for (int i = 0; i < 3; i++)
            tick("l_hold", 1, 0, 1);
        bus.hlock   = 4'b0000;
        bus.htrans  = IDLE;
        bus.hburst  = 3'd0;
        tick("l_rel", 4, 0, -1);
        tick("l_own", 4, 2, 0);

        // starvation aging
        do_reset();
        bus.prio    = {3'd0, 3'd0, 3'd0, 3'd7};
        bus.hbusreq = 4'b0011;
        bus.htrans  = NONSEQ;
        bus.hburst  = 3'd0;
        tick("age1", 1, 0, 0);
        tick("age2", 1, 0, 0);
        tick("age3", 1, 0, 0);
        tick("age4", AGING ? 2 : 1, 0, 0);
        tick("age5", 1, AGING ? 1 : 0, 0);
        tick("age6", 1, -1, -1);
        tick("age7", 1, -1, -1);

        // reset while m1 is still requesting
        hresetn = 1'b0;
        tick("rst_mid", 1, 0, 0);
        hresetn     = 1'b1;
        bus.hbusreq = '0;
        bus.htrans  = IDLE;
        tick("rst_park", 1, 0, 0);

        for (int i = 0; i < 4 && sb.size() != 0; i++)
            @(negedge hclk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
